rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of each requester data word.
REQ-002 Parameter MAX_BURST, default 4, range 1..16, maximum beats per grant before forced rotation.
REQ-003 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-004 Port list, clock and reset first:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  4  per-requester data valid, bit i = requester i
- in_data  input  4*DATA_W  packed requester data, requester i at bits [i*DATA_W +: DATA_W]
- in_ready  output  4  per-requester accept
- out_valid  output  1  shared output valid
- out_data  output  DATA_W  shared output data
- out_ready  input  1  downstream accept
- grant  output  4  one-hot current owner, all-zero when idle
- sel  output  2  select code of current or last owner; 00 selects requester 0, 11 selects requester 3

Function
REQ-005 The block SHALL have two states: IDLE and BUSY.
REQ-006 In IDLE with any in_valid high, the block SHALL pick the first requester with in_valid high, searching from the priority pointer upward modulo 4.
- The next clock registers grant, sel and BUSY.
- Arbitration latency is 1 cycle from request to grant.
REQ-007 In IDLE with in_valid all zero, the block SHALL stay in IDLE and hold grant at 0.
REQ-008 The block SHALL drive out_valid = in_valid[sel] and out_data = in_data[sel] combinationally while in BUSY, and out_valid = 0 in IDLE.
REQ-009 The block SHALL drive in_ready[i] = out_ready AND grant[i], so non-granted requesters always see in_ready = 0.
REQ-010 A beat SHALL transfer on a rising edge where out_valid and out_ready are both high; the beat counter SHALL increment on each transfer.
REQ-011 The block SHALL release the grant (state to IDLE, grant to 0, pointer to sel+1 mod 4, beat counter to 0) on either event:
- a transfer that is beat MAX_BURST of the grant;
- a BUSY cycle with in_valid[sel] = 0.
REQ-012 After a release, the block SHALL spend one IDLE cycle (arbitration bubble) before the next grant, even when requests are pending.
REQ-013 With MAX_BURST = 1, the block SHALL release after every transfer, giving strict per-beat rotation.
REQ-014 In BUSY with out_ready held low, the block SHALL hold grant, sel and the beat counter indefinitely, with no timeout.
REQ-015 The priority pointer SHALL wrap from 3 to 0.
REQ-016 A requester SHALL keep in_valid and in_data stable until its beat is accepted; the arbiter does not check this rule.
REQ-017 sel SHALL keep its last value in IDLE and change only when a new grant is registered.

Reset
REQ-018 When rst_n is low, the block SHALL immediately force:
- state IDLE, pointer 0, sel 2'b00, grant 4'b0000, beat counter 0;
- out_valid 0 and in_ready 4'b0000.
REQ-019 A reset asserted mid-burst SHALL abandon the burst with no further transfer; the first arbitration after reset release uses pointer 0.

Structure
REQ-020 A shared package mux_arb_pkg SHALL hold N_REQ = 4, SEL_W = 2 and the IDLE/BUSY state typedef.
REQ-021 The rotating first-set search SHALL be a combinational sub-module rr_priority_picker with inputs req[3:0] and ptr[1:0], and outputs a one-hot pick and its 2-bit code.
REQ-022 The data path SHALL be a 4:1 select indexed by sel, with no data registers inside the block.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single requester: in_valid = 0100, out_ready = 1, 3 beats then valid drops -> grant 0100 and sel 10 one cycle after request; 3 transfers; release; pointer = 3.
- All request continuously, MAX_BURST = 4, out_ready = 1 -> grants 0001, 0010, 0100, 1000, 0001; 4 beats each; 1 idle bubble between grants.
- Backpressure: owner 1 mid-burst with out_ready = 0 for 10 cycles -> grant, sel and beat count unchanged; in_ready = 0000; burst resumes with no beat lost or duplicated.
- MAX_BURST = 1 with requesters 0 and 2 continuously valid -> alternating single-beat grants 0001, 0100, 0001, each separated by one idle cycle.
- Reset mid-burst: rst_n low during beat 2 of owner 3 -> same-cycle out_valid = 0, grant = 0000, sel = 00; after release with all requesting, first grant = 0001.
- Pointer wrap: owner 3 releases, then requesters 0 and 2 valid -> grant 0001.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state type for the round-robin mux arbiter
package mux_arb_pkg;
   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - rotating first-set search starting at ptr, wrapping modulo N_REQ
import mux_arb_pkg::*;

module rr_priority_picker (
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_REQ-1:0] pick,
   output logic [SEL_W-1:0] code
);

   logic             w_found;
   logic [SEL_W-1:0] w_idx;

   always_comb begin
      pick    = '0;
      code    = ptr;
      w_found = 1'b0;
      w_idx   = ptr;
      for (int k = 0; k < N_REQ; k++) begin
         // 2-bit addition wraps 3 back to 0
         w_idx = ptr + SEL_W'(k);
         if (!w_found && req[w_idx]) begin
            w_found     = 1'b1;
            pick[w_idx] = 1'b1;
            code        = w_idx;
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - 4-way round-robin burst arbiter steering one requester onto a shared stream
import mux_arb_pkg::*;

module rr_mux_arbiter #(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        in_valid,
   input  logic [N_REQ*DATA_W-1:0] in_data,
   output logic [N_REQ-1:0]        in_ready,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   input  logic                    out_ready,
   output logic [N_REQ-1:0]        grant,
   output logic [SEL_W-1:0]        sel
);

   localparam int BEAT_W = $clog2(MAX_BURST + 1);

   arb_state_t         r_state;
   logic [SEL_W-1:0]   r_ptr;
   logic [SEL_W-1:0]   r_sel;
   logic [N_REQ-1:0]   r_grant;
   logic [BEAT_W-1:0]  r_beat;

   arb_state_t         w_state_nxt;
   logic [SEL_W-1:0]   w_ptr_nxt;
   logic [SEL_W-1:0]   w_sel_nxt;
   logic [N_REQ-1:0]   w_grant_nxt;
   logic [BEAT_W-1:0]  w_beat_nxt;

   logic [N_REQ-1:0]   w_pick;
   logic [SEL_W-1:0]   w_code;
   logic               w_xfer;
   logic               w_last;

   rr_priority_picker u_picker (
      .req  (in_valid),
      .ptr  (r_ptr),
      .pick (w_pick),
      .code (w_code)
   );

   assign out_valid = (r_state == BUSY) && in_valid[r_sel];
   assign out_data  = in_data[r_sel*DATA_W +: DATA_W];
   assign in_ready  = {N_REQ{out_ready}} & r_grant;
   assign grant     = r_grant;
   assign sel       = r_sel;

   assign w_xfer = out_valid && out_ready;
   assign w_last = (r_beat == BEAT_W'(MAX_BURST - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_sel_nxt   = r_sel;
      w_grant_nxt = r_grant;
      w_beat_nxt  = r_beat;
      case (r_state)
         IDLE: begin
            if (|in_valid) begin
               w_state_nxt = BUSY;
               w_grant_nxt = w_pick;
               w_sel_nxt   = w_code;
               w_beat_nxt  = '0;
            end
         end
         BUSY: begin
            // owner withdrew or just finished its final permitted beat
            if (!in_valid[r_sel] || (w_xfer && w_last)) begin
               w_state_nxt = IDLE;
               w_grant_nxt = '0;
               w_ptr_nxt   = r_sel + SEL_W'(1);
               w_beat_nxt  = '0;
            end else if (w_xfer) begin
               w_beat_nxt = r_beat + BEAT_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_grant <= '0;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_sel   <= w_sel_nxt;
         r_grant <= w_grant_nxt;
         r_beat  <= w_beat_nxt;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - self-checking bench for rr_mux_arbiter (MAX_BURST 4 and 1 instances)
module tb_rr_mux_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic [3:0]  rdy4, gr4, rdy1, gr1;
   logic        ov4, ov1;
   logic [7:0]  od4, od1;
   logic [1:0]  sl4, sl1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy4), .out_valid(ov4), .out_data(od4), .out_ready(out_ready),
      .grant(gr4), .sel(sl4)
   );

   rr_mux_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
      .grant(gr1), .sel(sl1)
   );

   // Reference model: owner index (-1 = nobody), next-search start, beats taken, last owner.
   int m_owner [2];
   int m_ptr   [2];
   int m_beats [2];
   int m_sel   [2];
   int m_lim   [2] = '{4, 1};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_ptr[k] = 0; m_beats[k] = 0; m_sel[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_owner[k] < 0) begin
               for (int j = 0; j < 4; j++) begin
                  if (m_owner[k] < 0 && in_valid[(m_ptr[k] + j) % 4]) begin
                     m_owner[k] = (m_ptr[k] + j) % 4;
                     m_sel[k]   = m_owner[k];
                     m_beats[k] = 0;
                  end
               end
            end else if (!in_valid[m_owner[k]]) begin
               m_ptr[k] = (m_owner[k] + 1) % 4; m_owner[k] = -1; m_beats[k] = 0;
            end else if (out_ready) begin
               m_beats[k] = m_beats[k] + 1;
               if (m_beats[k] == m_lim[k]) begin
                  m_ptr[k] = (m_owner[k] + 1) % 4; m_owner[k] = -1; m_beats[k] = 0;
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 4'b1111; in_data = 32'h44332211; out_ready = 1'b1;
      #3;
      checks++; if (gr4 !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", gr4); end
      checks++; if (sl4 !== 2'b00) begin errors++; $display("FAIL reset_sel got=%b exp=00", sl4); end
      checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov4); end
      checks++; if (rdy4 !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", rdy4); end
      do_reset();
   endtask

   task automatic test_single();
      int xfers = 0;
      int n = 0;
      do_reset();
      in_valid = 4'b0100; out_ready = 1'b1; in_data = 32'h00AA0000;
      @(negedge clk); #1;
      checks++; if (gr4 !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", gr4); end
      checks++; if (sl4 !== 2'b10) begin errors++; $display("FAIL single_sel got=%b exp=10", sl4); end
      checks++; if (od4 !== 8'hAA) begin errors++; $display("FAIL single_data got=%h exp=aa", od4); end
      while (xfers < 3 && n < 20) begin
         if (ov4 && out_ready) xfers++;
         @(negedge clk); #1; n++;
      end
      in_valid = 4'b0000;
      checks++; if (gr4 !== 4'b0100) begin errors++; $display("FAIL single_hold got=%b exp=0100", gr4); end
      @(negedge clk); #1;
      checks++; if (gr4 !== 4'b0000) begin errors++; $display("FAIL single_release got=%b exp=0000", gr4); end
      checks++; if (xfers !== 3) begin errors++; $display("FAIL single_xfers got=%0d exp=3", xfers); end
      in_valid = 4'b1111;
      @(negedge clk); #1;
      checks++; if (gr4 !== 4'b1000) begin errors++; $display("FAIL single_ptr3 got=%b exp=1000", gr4); end
   endtask

   task automatic test_all_request();
      logic [3:0] exp;
      do_reset();
      in_valid = 4'b1111; out_ready = 1'b1; in_data = 32'h44332211;
      for (int c = 0; c < 21; c++) begin
         @(negedge clk); #1;
         exp = (c % 5 == 4) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
         checks++; if (gr4 !== exp) begin errors++; $display("FAIL all_grant c=%0d got=%b exp=%b", c, gr4, exp); end
         checks++; if (rdy4 !== exp) begin errors++; $display("FAIL all_in_ready c=%0d got=%b exp=%b", c, rdy4, exp); end
      end
   endtask

   task automatic test_backpressure();
      int xfers = 0, stall = 0, idx = 0;
      bit granted = 0, done = 0;
      do_reset();
      in_valid = 4'b0010;
      for (int n = 0; n < 60 && !done; n++) begin
         out_ready = !(xfers == 2 && stall < 10);
         in_data   = {16'h0, 8'(8'h50 + idx), 8'h0};
         #1;
         if (gr4 === 4'b0010) granted = 1;
         else if (granted) done = 1;
         if (!out_ready && granted) begin
            stall++;
            checks++; if (gr4 !== 4'b0010 || sl4 !== 2'b01 || rdy4 !== 4'b0000)
               begin errors++; $display("FAIL bp_hold grant=%b sel=%b in_ready=%b exp 0010/01/0000", gr4, sl4, rdy4); end
         end
         if (ov4 && out_ready && !done) begin
            checks++; if (od4 !== 8'(8'h50 + idx))
               begin errors++; $display("FAIL bp_data got=%h exp=%h", od4, 8'(8'h50 + idx)); end
            idx++; xfers++;
         end
         @(negedge clk);
      end
      checks++; if (!done) begin errors++; $display("FAIL bp_release got=not_released exp=released"); end
      checks++; if (xfers !== 4) begin errors++; $display("FAIL bp_xfers got=%0d exp=4", xfers); end
      checks++; if (stall !== 10) begin errors++; $display("FAIL bp_stall got=%0d exp=10", stall); end
   endtask

   task automatic test_burst1();
      logic [3:0] exp_seq [5] = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
      do_reset();
      in_valid = 4'b0101; out_ready = 1'b1; in_data = 32'h00CC00BB;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         checks++; if (gr1 !== exp_seq[c]) begin errors++; $display("FAIL burst1 c=%0d got=%b exp=%b", c, gr1, exp_seq[c]); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 4'b1000; out_ready = 1'b1; in_data = 32'h77000000;
      @(negedge clk); #1;
      checks++; if (gr4 !== 4'b1000) begin errors++; $display("FAIL rstmid_grant got=%b exp=1000", gr4); end
      @(negedge clk);
      rst_n = 1'b0; #1;
      checks++; if (ov4 !== 1'b0 || gr4 !== 4'b0000 || sl4 !== 2'b00 || rdy4 !== 4'b0000)
         begin errors++; $display("FAIL rstmid_force ov=%b grant=%b sel=%b rdy=%b exp 0/0000/00/0000", ov4, gr4, sl4, rdy4); end
      in_valid = 4'b1111;
      @(negedge clk); #1;
      checks++; if (gr4 !== 4'b0000) begin errors++; $display("FAIL rstmid_held got=%b exp=0000", gr4); end
      rst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if (gr4 !== 4'b0001) begin errors++; $display("FAIL rstmid_first got=%b exp=0001", gr4); end
   endtask

   task automatic test_wrap();
      do_reset();
      in_valid = 4'b1000; out_ready = 1'b0; in_data = 32'h0;
      @(negedge clk); #1;
      checks++; if (gr4 !== 4'b1000 || sl4 !== 2'b11) begin errors++; $display("FAIL wrap_own3 grant=%b sel=%b exp 1000/11", gr4, sl4); end
      in_valid = 4'b0101;
      @(negedge clk); #1;
      checks++; if (gr4 !== 4'b0000 || sl4 !== 2'b11) begin errors++; $display("FAIL wrap_idle grant=%b sel=%b exp 0000/11", gr4, sl4); end
      @(negedge clk); #1;
      checks++; if (gr4 !== 4'b0001) begin errors++; $display("FAIL wrap_grant got=%b exp=0001", gr4); end
   endtask

   task automatic test_random();
      logic [3:0] eg, er, g, r;
      logic [1:0] es, s;
      logic       ev, v;
      logic [7:0] ed, d;
      do_reset();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) in_valid = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 150) == 0) rst_n = 1'b0; else rst_n = 1'b1;
         #1;
         for (int k = 0; k < 2; k++) begin
            eg = (m_owner[k] < 0) ? 4'b0000 : 4'(1 << m_owner[k]);
            er = out_ready ? eg : 4'b0000;
            es = 2'(m_sel[k]);
            ev = (m_owner[k] >= 0) && in_valid[m_owner[k]];
            ed = in_data[m_sel[k]*8 +: 8];
            g = k ? gr1 : gr4; r = k ? rdy1 : rdy4; s = k ? sl1 : sl4;
            v = k ? ov1 : ov4; d = k ? od1 : od4;
            checks++; if (g !== eg || r !== er || s !== es || v !== ev || (ev && d !== ed))
               begin errors++; $display("FAIL rand n=%0d inst=%0d grant=%b/%b rdy=%b/%b sel=%b/%b valid=%b/%b data=%h/%h (got/exp)",
                                        n, k, g, eg, r, er, s, es, v, ev, d, ed); end
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_request();
      test_backpressure();
      test_burst1();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
